linefill_bus_ctrl: RTL and testbench

//  Cache-line bus engine between the I$/D$ and the AHB-Lite bus. Turns a cache line fetch or writeback

---
 rtl/linefill_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_linefill_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/linefill_bus_ctrl.sv
// Cache line bus engine: turns a line fetch or writeback request into one AHB-Lite
// incrementing burst, assembling fetched beats and streaming writeback words.
module linefill_bus_ctrl #(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 64,
    parameter int LINELEN = 512,
    parameter int LOGBWPL = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic               FlushStage,
    input  logic [AHBW-1:0]    ReadDataWord,
    output logic               CacheBusAck,
    output logic               BusCommitted,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic [PA_BITS-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HBURST,
    output logic [2:0]         HSIZE,
    output logic [AHBW-1:0]    HWDATA,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HRDATA
);

    localparam int BEATS = LINELEN / AHBW;
    localparam int OFF   = $clog2(LINELEN / 8);

    localparam logic [LOGBWPL:0] LAST_CNT = (LOGBWPL + 1)'(BEATS);
    localparam logic [2:0] BURST_C = (BEATS == 4)  ? 3'b011 :
                                     (BEATS == 8)  ? 3'b101 :
                                     (BEATS == 16) ? 3'b111 : 3'b001;
    localparam logic [2:0] SIZE_C  = 3'($clog2(AHBW / 8));

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t             state_q, state_d;
    logic [LOGBWPL:0]   cnt_q, cnt_d;
    logic [LINELEN-1:0] fbuf_q, fbuf_d;
    logic [AHBW-1:0]    wdata_q, wdata_d;
    logic [LOGBWPL-1:0] data_beat;
    logic               start;
    logic               addr_open;
    logic               unused_adr;

    // Address counter runs one beat ahead of the data phase, so the data index is one behind.
    assign start      = (|CacheBusRW) & ~FlushStage & ~reset;
    assign addr_open  = cnt_q < LAST_CNT;
    assign data_beat  = cnt_q[LOGBWPL-1:0] - LOGBWPL'(1);
    assign unused_adr = ^CacheBusAdr[OFF-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fbuf_d      = fbuf_q;
        wdata_d     = wdata_q;
        HTRANS      = TR_IDLE;
        HWRITE      = 1'b0;
        CacheBusAck = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    HTRANS = TR_NONSEQ;
                    HWRITE = CacheBusRW[0];
                    if (HREADY) begin
                        cnt_d = (LOGBWPL + 1)'(1);
                        if (CacheBusRW[0]) begin
                            state_d = WRITE;
                            wdata_d = ReadDataWord;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            FETCH, WRITE: begin
                HTRANS = addr_open ? TR_SEQ : TR_IDLE;
                HWRITE = (state_q == WRITE);
                if (HREADY) begin
                    if (addr_open) cnt_d = cnt_q + 1'b1;
                    if (state_q == FETCH) begin
                        fbuf_d[data_beat*AHBW +: AHBW] = HRDATA;
                    end else if (addr_open) begin
                        wdata_d = ReadDataWord;
                    end
                    if (cnt_q == LAST_CNT) begin
                        CacheBusAck = ~reset;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fbuf_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fbuf_q  <= fbuf_d;
            wdata_q <= wdata_d;
        end
    end

    // The ack cycle exposes the final beat straight from HRDATA so the cache can use the line at once.
    assign FetchBuffer  = CacheBusAck ? fbuf_d : fbuf_q;
    assign BeatCount    = cnt_q[LOGBWPL-1:0];
    assign HADDR        = {CacheBusAdr[PA_BITS-1:OFF], BeatCount, {(OFF - LOGBWPL){1'b0}}};
    assign HWDATA       = wdata_q;
    assign HBURST       = BURST_C;
    assign HSIZE        = SIZE_C;
    assign BusCommitted = (state_q != IDLE);
    assign SelBusBeat   = (state_q == WRITE);

endmodule

// File: tb/tb_linefill_bus_ctrl.sv
// Bench for linefill_bus_ctrl: cycle table for fetch timing, hand sequences for corner
// cases, and randomized bursts scored against a transaction-level model.
module tb_linefill_bus_ctrl;
    localparam int BEATS = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   CacheBusRW;
    logic [31:0]  CacheBusAdr;
    logic         FlushStage;
    logic [63:0]  ReadDataWord;
    logic         CacheBusAck;
    logic         BusCommitted;
    logic         SelBusBeat;
    logic [2:0]   BeatCount;
    logic [511:0] FetchBuffer;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HBURST;
    logic [2:0]   HSIZE;
    logic [63:0]  HWDATA;
    logic         HREADY;
    logic [63:0]  HRDATA;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] salt;
    logic [31:0] dp_addr;
    logic [63:0] wb_base;

    linefill_bus_ctrl dut (
        .clk(clk), .reset(reset), .CacheBusRW(CacheBusRW), .CacheBusAdr(CacheBusAdr),
        .FlushStage(FlushStage), .ReadDataWord(ReadDataWord), .CacheBusAck(CacheBusAck),
        .BusCommitted(BusCommitted), .SelBusBeat(SelBusBeat), .BeatCount(BeatCount),
        .FetchBuffer(FetchBuffer), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HBURST(HBURST), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    always #5 clk = ~clk;

    // Cache side: writeback word is a function of the beat index it selects.
    assign ReadDataWord = wb_base + 64'(BeatCount);

    // Memory model: data phase returns a word derived from the address accepted last.
    always @(posedge clk) begin
        if (reset) dp_addr <= '0;
        else if (HREADY && HTRANS[1]) dp_addr <= HADDR;
    end
    assign HRDATA = {salt, 3'b000, dp_addr[31:3]};

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {salt, 3'b000, a[31:3]};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One request from the cache until ack, scored at transaction level.
    task automatic do_txn(input logic [1:0] rw, input logic [31:0] adr, input int pct,
                          input bit flush_mid);
        logic [31:0]  aq[$];
        logic [1:0]   tq[$];
        logic         wq[$];
        logic [63:0]  dq[$];
        logic [511:0] fb_ack = '0;
        logic [511:0] exp_fb;
        int  cyc = 0;
        int  rdy_cnt = 0;
        bit  dp = 1'b0;
        bit  done = 1'b0;
        bit  is_wr = rw[0];
        CacheBusRW  = rw;
        CacheBusAdr = adr;
        FlushStage  = 1'b0;
        while (!done && cyc < 400) begin
            HREADY = ($urandom_range(99) < pct);
            if (flush_mid && rdy_cnt > 0) FlushStage = 1'b1;
            @(negedge clk);
            chk("committed", 512'(BusCommitted), 512'(rdy_cnt > 0));
            chk("selbusbeat", 512'(SelBusBeat), 512'((rdy_cnt > 0) && is_wr));
            if (HREADY) rdy_cnt++;
            if (dp && HREADY) begin
                dq.push_back(HWDATA);
                dp = 1'b0;
            end
            if (HTRANS[1] && HREADY) begin
                aq.push_back(HADDR);
                tq.push_back(HTRANS);
                wq.push_back(HWRITE);
                dp = 1'b1;
            end
            if (CacheBusAck) begin
                done   = 1'b1;
                fb_ack = FetchBuffer;
            end
            next_cycle();
            cyc++;
        end
        CacheBusRW = 2'b00;
        FlushStage = 1'b0;
        HREADY     = 1'b1;
        chk("ack_seen", 512'(done), 512'(1));
        chk("ack_latency_ready_cycles", 512'(rdy_cnt), 512'(BEATS + 1));
        chk("addr_phases", 512'(aq.size()), 512'(BEATS));
        foreach (aq[i]) begin
            chk("haddr", 512'(aq[i]), 512'(adr + 32'(8 * i)));
            chk("htrans", 512'(tq[i]), 512'((i == 0) ? 2'b10 : 2'b11));
            chk("hwrite", 512'(wq[i]), 512'(is_wr));
        end
        if (is_wr) begin
            chk("wdata_beats", 512'(dq.size()), 512'(BEATS));
            foreach (dq[i]) chk("hwdata", 512'(dq[i]), 512'(wb_base + 64'(i)));
        end else begin
            for (int i = 0; i < BEATS; i++) exp_fb[i*64 +: 64] = mem_word(adr + 32'(8 * i));
            chk("fetchbuffer", fb_ack, exp_fb);
        end
        @(negedge clk);
        chk("post_ack_quiet", 512'({CacheBusAck, HTRANS, BusCommitted}), 512'(0));
        next_cycle();
    endtask

    typedef struct {
        bit         start;
        bit         rdy;
        logic [1:0] tr;
        logic [2:0] bc;
        bit         ack;
        bit         com;
    } vec_t;

    function automatic vec_t mkv(input bit s, input bit r, input logic [1:0] t,
                                 input logic [2:0] b, input bit a, input bit c);
        vec_t v;
        v.start = s; v.rdy = r; v.tr = t; v.bc = b; v.ack = a; v.com = c;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[20];
        logic [511:0] line_i;
        logic [1:0]   rw;
        logic [31:0]  adr;

        // Zero-wait fetch of line 0, then the same fetch with HREADY low for 2 cycles at beat 3.
        tbl[0]  = mkv(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0);
        tbl[1]  = mkv(1'b0, 1'b1, 2'b11, 3'd1, 1'b0, 1'b1);
        tbl[2]  = mkv(1'b0, 1'b1, 2'b11, 3'd2, 1'b0, 1'b1);
        tbl[3]  = mkv(1'b0, 1'b1, 2'b11, 3'd3, 1'b0, 1'b1);
        tbl[4]  = mkv(1'b0, 1'b1, 2'b11, 3'd4, 1'b0, 1'b1);
        tbl[5]  = mkv(1'b0, 1'b1, 2'b11, 3'd5, 1'b0, 1'b1);
        tbl[6]  = mkv(1'b0, 1'b1, 2'b11, 3'd6, 1'b0, 1'b1);
        tbl[7]  = mkv(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 1'b1);
        tbl[8]  = mkv(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, 1'b1);
        tbl[9]  = mkv(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0);
        tbl[10] = mkv(1'b0, 1'b1, 2'b11, 3'd1, 1'b0, 1'b1);
        tbl[11] = mkv(1'b0, 1'b1, 2'b11, 3'd2, 1'b0, 1'b1);
        tbl[12] = mkv(1'b0, 1'b0, 2'b11, 3'd3, 1'b0, 1'b1);
        tbl[13] = mkv(1'b0, 1'b0, 2'b11, 3'd3, 1'b0, 1'b1);
        tbl[14] = mkv(1'b0, 1'b1, 2'b11, 3'd3, 1'b0, 1'b1);
        tbl[15] = mkv(1'b0, 1'b1, 2'b11, 3'd4, 1'b0, 1'b1);
        tbl[16] = mkv(1'b0, 1'b1, 2'b11, 3'd5, 1'b0, 1'b1);
        tbl[17] = mkv(1'b0, 1'b1, 2'b11, 3'd6, 1'b0, 1'b1);
        tbl[18] = mkv(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 1'b1);
        tbl[19] = mkv(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < BEATS; i++) line_i[i*64 +: 64] = 64'(i);

        reset = 1'b1; CacheBusRW = 2'b00; CacheBusAdr = '0; FlushStage = 1'b0;
        HREADY = 1'b1; salt = '0; wb_base = 64'hA0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_htrans", 512'(HTRANS), 512'(0));
        chk("rst_ctrl", 512'({HWRITE, BeatCount, CacheBusAck, BusCommitted, SelBusBeat}), 512'(0));
        chk("rst_fetchbuffer", FetchBuffer, 512'(0));
        chk("rst_hwdata", 512'(HWDATA), 512'(0));
        chk("hburst", 512'(HBURST), 512'(3'b101));
        chk("hsize", 512'(HSIZE), 512'(3'b011));
        next_cycle();
        reset = 1'b0;
        next_cycle();

        foreach (tbl[i]) begin
            if (tbl[i].start) begin
                CacheBusRW  = 2'b10;
                CacheBusAdr = '0;
            end
            HREADY = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_htrans", i), 512'(HTRANS), 512'(tbl[i].tr));
            chk($sformatf("tbl%0d_beatcount", i), 512'(BeatCount), 512'(tbl[i].bc));
            chk($sformatf("tbl%0d_haddr", i), 512'(HADDR), 512'({tbl[i].bc, 3'b000}));
            chk($sformatf("tbl%0d_ack", i), 512'(CacheBusAck), 512'(tbl[i].ack));
            chk($sformatf("tbl%0d_committed", i), 512'(BusCommitted), 512'(tbl[i].com));
            if (tbl[i].ack) chk($sformatf("tbl%0d_line", i), FetchBuffer, line_i);
            next_cycle();
            if (tbl[i].ack) CacheBusRW = 2'b00;
        end
        HREADY = 1'b1;

        // Writeback at 0x1000 with words 0xA0+BeatCount.
        do_txn(2'b01, 32'h0000_1000, 100, 1'b0);

        // Request suppressed by FlushStage while idle.
        CacheBusRW = 2'b10; CacheBusAdr = 32'h0000_2000; FlushStage = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_idle_htrans", 512'(HTRANS), 512'(0));
            chk("flush_idle_ack", 512'({CacheBusAck, BusCommitted}), 512'(0));
            next_cycle();
        end
        CacheBusRW = 2'b00; FlushStage = 1'b0;

        // FlushStage raised after the burst starts is ignored.
        salt = 32'h5A5A_0001;
        do_txn(2'b10, 32'h0000_2040, 100, 1'b1);

        // Both bits set: writeback first, then the follow-up fetch.
        wb_base = 64'h1234_0000_0000_0010;
        do_txn(2'b11, 32'h0000_3000, 100, 1'b0);
        do_txn(2'b10, 32'h0000_3000, 100, 1'b0);

        // Reset in the middle of a fetch, while BeatCount is 4.
        CacheBusRW = 2'b10; CacheBusAdr = 32'h0000_4000; HREADY = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        reset = 1'b1; CacheBusRW = 2'b00;
        @(negedge clk);
        chk("pre_reset_beat", 512'(BeatCount), 512'(4));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_htrans", 512'(HTRANS), 512'(0));
        chk("abort_beatcount", 512'(BeatCount), 512'(0));
        chk("abort_fetchbuffer", FetchBuffer, 512'(0));
        chk("abort_ack", 512'({CacheBusAck, BusCommitted}), 512'(0));
        next_cycle();
        @(negedge clk);
        chk("abort_no_late_ack", 512'(CacheBusAck), 512'(0));
        next_cycle();

        // Randomized bursts with random wait states and idle gaps.
        for (int n = 0; n < 25; n++) begin
            rw      = 2'($urandom_range(1, 3));
            adr     = $urandom & 32'hFFFF_FFC0;
            salt    = $urandom;
            wb_base = {$urandom, $urandom};
            do_txn(rw, adr, int'($urandom_range(35, 100)), 1'($urandom_range(1)));
            for (int g = 0; g < int'($urandom_range(2)); g++) begin
                FlushStage = 1'($urandom_range(1));
                CacheBusRW = FlushStage ? 2'b10 : 2'b00;
                HREADY     = 1'($urandom_range(1));
                @(negedge clk);
                chk("gap_htrans", 512'(HTRANS), 512'(0));
                next_cycle();
            end
            CacheBusRW = 2'b00; FlushStage = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
